// File: rtl/dc_reload_ctrl_pkg.sv
// Shared types for the DC reload path: DC count, DC index type and reload FSM encoding.
package core0_dc_pkg;

  localparam int unsigned NUM_DC   = 4;
  localparam int unsigned DC_SEL_W = 2;

  typedef logic [DC_SEL_W-1:0] dc_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dc_reload_state_t;

endpackage

// File: rtl/dc_reload_ctrl_if.sv
// Data-memory read port used by the DC reload controller: request channel plus response pulse.
interface dc_reload_ctrl_if #(
  parameter int unsigned WORD_WIDTH = 32
);

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [WORD_WIDTH-1:0] rd_req_addr;
  logic                  rd_resp_valid;
  logic [WORD_WIDTH-1:0] rd_resp_data;

  modport master (
    output rd_req_valid,
    output rd_req_addr,
    input  rd_req_ready,
    input  rd_resp_valid,
    input  rd_resp_data
  );

  modport slave (
    input  rd_req_valid,
    input  rd_req_addr,
    output rd_req_ready,
    output rd_resp_valid,
    output rd_resp_data
  );

endinterface

// File: rtl/dc_reload_ctrl_rr_arbiter.sv
// Round-robin picker over the per-DC pending flags; search starts after the last grant.
module dc_rr_arbiter
  import core0_dc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_DC-1:0] req,
  input  logic              advance,
  output logic [NUM_DC-1:0] grant_c,
  output dc_sel_t           grant_idx_c
);

  dc_sel_t last_q;
  dc_sel_t cand;
  logic    found;

  // Scan last+1 .. last+4 (wrapping) and take the first requester.
  always_comb begin
    cand        = '0;
    found       = 1'b0;
    grant_idx_c = last_q;
    for (int k = 1; k <= NUM_DC; k++) begin
      cand = last_q + DC_SEL_W'(k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx_c = cand;
      end
    end
    grant_c = found ? (NUM_DC'(1) << grant_idx_c) : '0;
  end

  // Pointer resets to the last index so DC0 is served first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= DC_SEL_W'(NUM_DC - 1);
    end else if (advance && (|req)) begin
      last_q <= grant_idx_c;
    end
  end

endmodule

// File: rtl/dc_reload_ctrl.sv
// DC address registers, stale tracking and one-at-a-time reload fetch from data memory.
// Optional: DC_RELOAD_SQUASH_EN drops responses whose DC was re-mutated while in flight.
module dc_reload_ctrl
  import core0_dc_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               addr_set_valid,
  input  dc_sel_t                            addr_set_sel,
  input  logic [WORD_WIDTH-1:0]              addr_set_data,
  input  logic                               addr_inc_valid,
  input  dc_sel_t                            addr_inc_sel,
  dc_reload_ctrl_if.master                   mem,
  output logic                               dc_reload,
  output dc_sel_t                            dc_mutate,
  output logic [WORD_WIDTH-1:0]              mem_in,
  output logic [NUM_DC-1:0][WORD_WIDTH-1:0]  dc_addrs,
  output logic [NUM_DC-1:0]                  dc_pending
);

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_REQ  = 2'(REQ);
  localparam logic [1:0] S_WAIT = 2'(WAIT);

  logic [1:0]                       state_q, state_d;
  dc_sel_t                          cur_sel_q, cur_sel_d;
  logic                             req_valid_q, req_valid_d;
  word_t                            req_addr_q, req_addr_d;
  logic                             reload_d;
  dc_sel_t                          mutate_d;
  word_t                            mem_in_d;
  logic [NUM_DC-1:0][WORD_WIDTH-1:0] addr_nxt;
  logic [NUM_DC-1:0]                upd, pend_clr, pending_d;
  logic [NUM_DC-1:0]                arb_grant;
  dc_sel_t                          arb_idx;
  logic                             arb_advance;
  logic                             drop;
`ifdef DC_RELOAD_SQUASH_EN
  logic                             stale_q, stale_d;
`endif

  dc_rr_arbiter u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (dc_pending),
    .advance     (arb_advance),
    .grant_c     (arb_grant),
    .grant_idx_c (arb_idx)
  );

  // Address update: set beats increment on the same DC; distinct DCs both apply.
  always_comb begin
    addr_nxt = dc_addrs;
    upd      = '0;
    for (int i = 0; i < NUM_DC; i++) begin
      if (addr_set_valid && (addr_set_sel == DC_SEL_W'(i))) begin
        addr_nxt[i] = addr_set_data;
        upd[i]      = 1'b1;
      end else if (addr_inc_valid && (addr_inc_sel == DC_SEL_W'(i))) begin
        addr_nxt[i] = dc_addrs[i] + WORD_WIDTH'(1);
        upd[i]      = 1'b1;
      end
    end
  end

  // Reload FSM next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    reload_d    = 1'b0;
    mutate_d    = dc_mutate;
    mem_in_d    = mem_in;
    pend_clr    = '0;
    arb_advance = 1'b0;
    drop        = 1'b0;
`ifdef DC_RELOAD_SQUASH_EN
    stale_d     = stale_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          arb_advance = 1'b1;
          cur_sel_d   = arb_idx;
          req_addr_d  = addr_nxt[arb_idx];
          req_valid_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.rd_req_ready) begin
          req_valid_d         = 1'b0;
          pend_clr[cur_sel_q] = 1'b1;
          state_d             = S_WAIT;
`ifdef DC_RELOAD_SQUASH_EN
          stale_d             = upd[cur_sel_q];
`endif
        end
      end
      S_WAIT: begin
`ifdef DC_RELOAD_SQUASH_EN
        stale_d = stale_q | upd[cur_sel_q];
        drop    = stale_d;
`endif
        if (mem.rd_resp_valid) begin
          state_d = S_IDLE;
          if (!drop) begin
            reload_d = 1'b1;
            mutate_d = cur_sel_q;
            mem_in_d = mem.rd_resp_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = (dc_pending & ~pend_clr) | upd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cur_sel_q   <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      dc_reload   <= 1'b0;
      dc_mutate   <= '0;
      mem_in      <= '0;
      dc_addrs    <= '0;
      dc_pending  <= '0;
`ifdef DC_RELOAD_SQUASH_EN
      stale_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      dc_reload   <= reload_d;
      dc_mutate   <= mutate_d;
      mem_in      <= mem_in_d;
      dc_addrs    <= addr_nxt;
      dc_pending  <= pending_d;
`ifdef DC_RELOAD_SQUASH_EN
      stale_q     <= stale_d;
`endif
    end
  end

  assign mem.rd_req_valid = req_valid_q;
  assign mem.rd_req_addr  = req_addr_q;

endmodule
